// File: rtl/imem_loader_pkg.sv
// Shared pipeline definitions for the instruction-memory loader and the IF stage.
// Holds the word/byte geometry, the halt encoding and the loader state encoding.
package imem_loader_pkg;

    localparam int unsigned INST_SZ_DEF   = 32;
    localparam int unsigned BYTE_SZ_DEF   = 8;
    localparam logic [31:0] HALT_INST_DEF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRecv  = 3'd1,
        StWrite = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } load_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write side of the program loader.
// The master modport is the host/stream side, the slave modport is the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned INST_SZ = INST_SZ_DEF,
    parameter int unsigned BYTE_SZ = BYTE_SZ_DEF,
    parameter int unsigned ADDR_SZ = 10
);

    logic               i_start;
    logic [BYTE_SZ-1:0] i_byte;
    logic               i_byte_valid;
    logic               o_byte_ready;
    logic               o_wr_en;
    logic [ADDR_SZ-1:0] o_wr_addr;
    logic [INST_SZ-1:0] o_wr_data;
    logic               o_busy;
    logic               o_done;
    logic               o_overflow;
    logic [ADDR_SZ:0]   o_inst_count;

    modport master (
        output i_start, i_byte, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        input  o_busy, o_done, o_overflow, o_inst_count
    );

    modport slave (
        input  i_start, i_byte, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
        output o_busy, o_done, o_overflow, o_inst_count
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs stream bytes little-endian into an instruction word.
// o_word_next is the word including the byte accepted this cycle.
module imem_loader_byte_packer #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned BYTE_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [BYTE_SZ-1:0] i_byte,
    output logic [INST_SZ-1:0] o_word_next,
    output logic               o_word_complete
);

    localparam int unsigned NumBytes = INST_SZ / BYTE_SZ;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    logic [IdxW-1:0]    idx_q, idx_d;
    logic [INST_SZ-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (i_clear) begin
            idx_d = '0;
        end else if (i_accept) begin
            word_d[idx_q*BYTE_SZ +: BYTE_SZ] = i_byte;
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign o_word_next     = word_d;
    assign o_word_complete = i_accept && !i_clear && (idx_q == LastIdx);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a byte stream into words, writes them from
// address 0 up until the halt word or a full memory, and holds the PC off while busy.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned        INST_SZ   = INST_SZ_DEF,
    parameter int unsigned        BYTE_SZ   = BYTE_SZ_DEF,
    parameter int unsigned        ADDR_SZ   = 10,
    parameter logic [INST_SZ-1:0] HALT_INST = INST_SZ'(HALT_INST_DEF)
) (
    input logic          i_clk,
    input logic          i_reset,
    imem_loader_if.slave bus
);

    load_state_e        state_q, state_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [ADDR_SZ:0]   count_q, count_d;
    logic [INST_SZ-1:0] wr_data_q, wr_data_d;
    logic [INST_SZ-1:0] word_next;
    logic               word_complete;
    logic               accept;
    logic               clear;

    assign accept = (state_q == StRecv) && bus.i_byte_valid;
    // The packer index restarts whenever a new load is (re)armed.
    assign clear  = (state_q == StIdle) ||
                    (bus.i_start && ((state_q == StDone) || (state_q == StErr)));

    imem_loader_byte_packer #(
        .INST_SZ (INST_SZ),
        .BYTE_SZ (BYTE_SZ)
    ) u_byte_packer (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (clear),
        .i_accept        (accept),
        .i_byte          (bus.i_byte),
        .o_word_next     (word_next),
        .o_word_complete (word_complete)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                addr_d  = '0;
                count_d = '0;
                if (bus.i_start) state_d = StRecv;
            end
            StRecv: begin
                if (word_complete) begin
                    wr_data_d = word_next;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                if (wr_data_q == HALT_INST) begin
                    state_d = StDone;
                end else if (addr_q == '1) begin
                    state_d = StErr;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StRecv;
                end
            end
            StDone, StErr: begin
                if (bus.i_start) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.o_byte_ready = (state_q == StRecv);
    assign bus.o_wr_en      = (state_q == StWrite);
    assign bus.o_wr_addr    = addr_q;
    assign bus.o_wr_data    = wr_data_q;
    assign bus.o_busy       = (state_q == StRecv) || (state_q == StWrite);
    assign bus.o_done       = (state_q == StDone);
    assign bus.o_overflow   = (state_q == StErr);
    assign bus.o_inst_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: default-size DUT plus a 4-word DUT for the overflow path.
// Expected writes are queued when words are sent and popped by negedge monitors.
module tb_imem_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        int          cnt;
        logic        done;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    wr_t  exp_sq[$];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_SZ(10)) bus ();
    imem_loader_if #(.ADDR_SZ(2))  sbus ();

    imem_loader #(.ADDR_SZ(10)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    imem_loader #(.ADDR_SZ(2)) u_small (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (sbus.slave)
    );

    always @(negedge clk) begin : mon_main
        wr_t e;
        if (bus.o_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.o_wr_addr, bus.o_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_wr_addr !== e.addr || bus.o_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             bus.o_wr_addr, bus.o_wr_data, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_small
        wr_t e;
        if (sbus.o_wr_en === 1'b1) begin
            checks++;
            if (exp_sq.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         sbus.o_wr_addr, sbus.o_wr_data);
            end else begin
                e = exp_sq.pop_front();
                if ({8'b0, sbus.o_wr_addr} !== e.addr || sbus.o_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL small_write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             sbus.o_wr_addr, sbus.o_wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sm, input logic st, input logic [7:0] b, input logic v);
        if (sm) begin
            sbus.i_start = st; sbus.i_byte = b; sbus.i_byte_valid = v;
        end else begin
            bus.i_start = st; bus.i_byte = b; bus.i_byte_valid = v;
        end
    endtask

    function automatic logic ready(input bit sm);
        return sm ? sbus.o_byte_ready : bus.o_byte_ready;
    endfunction

    task automatic start_load(input bit sm);
        drive(sm, 1'b1, 8'h00, 1'b0);
        tick();
        drive(sm, 1'b0, 8'h00, 1'b0);
    endtask

    // Presents one byte and returns just after the edge that accepts it.
    task automatic send_byte(input bit sm, input logic [7:0] b);
        int n = 0;
        drive(sm, 1'b0, b, 1'b1);
        while (!ready(sm) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got no o_byte_ready in 50 cycles, expected ready");
        end
        tick();
        drive(sm, 1'b0, b, 1'b0);
    endtask

    task automatic send_word(input bit sm, input logic [31:0] w, input logic [9:0] addr);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (sm) exp_sq.push_back(e);
        else    exp_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(sm, w[i*8 +: 8]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_byte_ready"}, bus.o_byte_ready, 0);
        check({tag, "_wr_en"},      bus.o_wr_en, 0);
        check({tag, "_wr_addr"},    bus.o_wr_addr, 0);
        check({tag, "_wr_data"},    bus.o_wr_data, 0);
        check({tag, "_busy"},       bus.o_busy, 0);
        check({tag, "_done"},       bus.o_done, 0);
        check({tag, "_overflow"},   bus.o_overflow, 0);
        check({tag, "_inst_count"}, bus.o_inst_count, 0);
    endtask

    initial begin : main
        vec_t        vecs[5];
        logic [7:0]  stream[8];
        logic [31:0] w;
        logic        rdy;
        int          idx;
        int          n;

        vecs[0] = '{word: 32'h0000_0013, cnt: 1, done: 1'b0, busy: 1'b1};
        vecs[1] = '{word: 32'h00A0_0093, cnt: 2, done: 1'b0, busy: 1'b1};
        vecs[2] = '{word: 32'hFFFF_FFFE, cnt: 3, done: 1'b0, busy: 1'b1};
        vecs[3] = '{word: 32'h8000_0000, cnt: 4, done: 1'b0, busy: 1'b1};
        vecs[4] = '{word: 32'hFFFF_FFFF, cnt: 5, done: 1'b1, busy: 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Table-driven program load ending in the halt word.
        start_load(1'b0);
        check("start_busy", bus.o_busy, 1);
        check("start_ready", bus.o_byte_ready, 1);
        for (int i = 0; i < 5; i++) begin
            send_word(1'b0, vecs[i].word, 10'(i));
            check("write_cycle_wr_en", bus.o_wr_en, 1);
            check("write_cycle_ready", bus.o_byte_ready, 0);
            tick();
            check("vec_inst_count", bus.o_inst_count, 64'(vecs[i].cnt));
            check("vec_done", bus.o_done, vecs[i].done);
            check("vec_busy", bus.o_busy, vecs[i].busy);
        end
        check("done_overflow", bus.o_overflow, 0);
        check("done_ready", bus.o_byte_ready, 0);
        check("done_wr_data_hold", bus.o_wr_data, 32'hFFFF_FFFF);
        check("done_wr_addr_hold", bus.o_wr_addr, 4);

        // Restart from DONE, then a stalled stream between bytes 2 and 3.
        start_load(1'b0);
        check("restart_done_clear", bus.o_done, 0);
        check("restart_addr", bus.o_wr_addr, 0);
        check("restart_count", bus.o_inst_count, 0);
        exp_q.push_back('{addr: 10'd0, data: 32'h4433_2211});
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_no_write", bus.o_wr_en, 0);
        end
        send_byte(1'b0, 8'h33);
        check("third_byte_no_write", bus.o_wr_en, 0);
        send_byte(1'b0, 8'h44);
        check("fourth_byte_write", bus.o_wr_en, 1);
        tick();
        check("write_one_cycle", bus.o_wr_en, 0);

        // Start pulse mid-load must be ignored.
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("recv_start_busy", bus.o_busy, 1);
        check("recv_start_addr", bus.o_wr_addr, 1);
        check("recv_start_count", bus.o_inst_count, 1);
        send_word(1'b0, 32'hFFFF_FFFF, 10'd1);
        tick();
        check("halt2_done", bus.o_done, 1);
        check("halt2_count", bus.o_inst_count, 2);

        // Reset after two bytes of a word, with start asserted in the same cycle.
        start_load(1'b0);
        send_byte(1'b0, 8'h55);
        send_byte(1'b0, 8'h66);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h77, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_reset_state("midload_reset");
        tick();
        check("post_reset_idle", bus.o_busy, 0);
        start_load(1'b0);
        send_word(1'b0, 32'hCAFE_F00D, 10'd0);
        send_word(1'b0, 32'hFFFF_FFFF, 10'd1);
        tick();
        check("post_reset_done", bus.o_done, 1);
        check("post_reset_count", bus.o_inst_count, 2);

        // Continuous stream with valid held high.
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        start_load(1'b0);
        exp_q.push_back('{addr: 10'd0, data: 32'h0403_0201});
        exp_q.push_back('{addr: 10'd1, data: 32'hFFFF_FFFF});
        idx = 0;
        n = 0;
        while (idx < 8 && n < 40) begin
            drive(1'b0, 1'b0, stream[idx], 1'b1);
            rdy = bus.o_byte_ready;
            tick();
            if (rdy) idx++;
            n++;
        end
        check("stream_cycles", 64'(n), 9);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("stream_done", bus.o_done, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_ignores_bytes", bus.o_inst_count, 2);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Overflow on a 4-word memory.
        start_load(1'b1);
        for (int k = 0; k < 4; k++) begin
            w = 32'h1111_1111 * (k + 1);
            send_word(1'b1, w, 10'(k));
        end
        tick();
        check("ovf_overflow", sbus.o_overflow, 1);
        check("ovf_done", sbus.o_done, 0);
        check("ovf_count", sbus.o_inst_count, 4);
        check("ovf_busy", sbus.o_busy, 0);
        drive(1'b1, 1'b0, 8'hAB, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_ready_low", sbus.o_byte_ready, 0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        start_load(1'b1);
        check("ovf_restart_clear", sbus.o_overflow, 0);
        check("ovf_restart_busy", sbus.o_busy, 1);
        check("ovf_restart_count", sbus.o_inst_count, 0);

        tick();
        tick();
        check("main_queue_empty", 64'(exp_q.size()), 0);
        check("small_queue_empty", 64'(exp_sq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
